// File: rtl/spram_arbiter_pkg.sv
// spram_arbiter_pkg
// Shared constants, the sequencer state type and an address range helper
// used by the SPRAM arbiter.
//   ADDR_W  word address width seen by both requesters and the SPRAM
//   DATA_W  data word width
//   STRB_W  number of byte write strobes
package spram_arbiter_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // True when a word address falls inside a memory of the given depth.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       words);
    return (32'(addr) < words);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin pick plus the register remembering the last grant.
// Ports:
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset (rr_last resets to 1 so the
//                first tie goes to port 0)
//   valid   in   [1:0] request lines, bit i = port i
//   update  in   a grant is being taken this cycle; latch it into rr_last
//   grant   out  selected port (only meaningful while any=1)
//   any     out  at least one request is pending
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid,
  input  logic       update,
  output logic       grant,
  output logic       any
);

  logic rr_last;

  // A lone requester always wins; on a tie the port that did not win last
  // time is chosen.
  always_comb begin
    any   = |valid;
    grant = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~rr_last;
      default: grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= 1'b1;
    end else if (update) begin
      rr_last <= grant;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter
// Two-requester round-robin sequencer in front of the iCE40UP5K SPRAM.
// Port 0 is the CPU, port 1 a secondary master. Every access takes
// IDLE -> ACCESS -> RESP, so a request sampled in cycle N completes with a
// one-cycle ready pulse in cycle N+2.
// Ports:
//   clk, resetn              clock and asynchronous active-low reset
//   req0_valid/ready         port 0 handshake (ready is a one-cycle pulse)
//   req0_addr/wstrb/wdata    port 0 word address, byte strobes (0 = read), data
//   req0_rdata               port 0 read data, nonzero only while req0_ready
//   req1_*                   same set for port 1
//   ram_wen/addr/wdata       SPRAM controls, registered
//   ram_rdata                SPRAM read data, valid the cycle after sampling
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int unsigned WORDS = 32768
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [STRB_W-1:0] req0_wstrb,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [STRB_W-1:0] req1_wstrb,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [STRB_W-1:0] ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t state;
  state_t state_next;

  logic              pick;
  logic              any_valid;
  logic              take;
  logic              grant_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              oob_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [STRB_W-1:0] sel_wstrb;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .resetn (resetn),
    .valid  ({req1_valid, req0_valid}),
    .update (take),
    .grant  (pick),
    .any    (any_valid)
  );

  // A grant is only taken from IDLE; requests arriving later simply wait.
  always_comb begin
    take         = (state == IDLE) && any_valid;
    sel_addr     = pick ? req1_addr  : req0_addr;
    sel_wstrb    = pick ? req1_wstrb : req0_wstrb;
    sel_wdata    = pick ? req1_wdata : req0_wdata;
    sel_in_range = addr_in_range(sel_addr, WORDS);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The request is captured straight into the SPRAM-facing registers so they
  // are stable for the whole ACCESS cycle. ram_wen defaults to zero every
  // cycle and is only loaded at grant, which confines it to ACCESS and keeps
  // out-of-range writes from ever reaching the SPRAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q   <= 1'b0;
      wstrb_q   <= '0;
      oob_q     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wen   <= '0;
    end else begin
      ram_wen <= '0;
      if (take) begin
        grant_q   <= pick;
        wstrb_q   <= sel_wstrb;
        oob_q     <= ~sel_in_range;
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
        if (sel_in_range) begin
          ram_wen <= sel_wstrb;
        end
      end
    end
  end

  // Ready is registered at the end of ACCESS so it is high exactly during
  // RESP, and only for the port that owns the access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
    end else begin
      req0_ready <= (state == ACCESS) && !grant_q;
      req1_ready <= (state == ACCESS) &&  grant_q;
    end
  end

  // SPRAM output is only valid during RESP, so read data is steered through
  // combinationally and gated by the granted port's ready.
  always_comb begin
    resp_data  = ((wstrb_q == '0) && !oob_q) ? ram_rdata : '0;
    req0_rdata = req0_ready ? resp_data : '0;
    req1_rdata = req1_ready ? resp_data : '0;
  end

endmodule
